// File: rtl/bubble_move_gen.sv
// Single-bubble motion engine: fixed-point position/velocity with wall, floor and
// ceiling rebounds, pause, and split/pop events carrying child launch data.
module bubble_move_gen #(
    parameter int unsigned FRAME_W     = 640,
    parameter int unsigned FRAME_H     = 480,
    parameter int unsigned FRAC_BITS   = 6,
    parameter int unsigned OBJECT_SIZE = 8,
    parameter int unsigned MAX_SIZE    = 4,
    parameter int unsigned X_SPEED     = 115,
    parameter int unsigned Y_ACCEL     = 2,
    parameter int unsigned BOUNCE_BASE = 320,
    parameter int unsigned BOUNCE_STEP = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic        start,
    input  logic [2:0]  size,
    input  logic        direction,
    input  logic [10:0] startTopX,
    input  logic [10:0] startTopY,
    input  logic        pause,
    input  logic        Hit,
    output logic [10:0] topLeftX,
    output logic [10:0] topLeftY,
    output logic [2:0]  size_out,
    output logic        active,
    output logic        split,
    output logic        pop,
    output logic [2:0]  child_size,
    output logic [10:0] child_x,
    output logic [10:0] child_y
);

    localparam int unsigned PW = 12 + FRAC_BITS;
    localparam int unsigned EW = PW + 2;
    localparam int unsigned M  = 1 << FRAC_BITS;

    localparam logic signed [PW-1:0] IDLE_POS  = PW'(0) - PW'(M);
    localparam logic signed [EW-1:0] FRAME_W_S = EW'(FRAME_W * M);
    localparam logic signed [EW-1:0] FRAME_H_S = EW'(FRAME_H * M);
    localparam logic signed [15:0]   VX_INIT   = 16'(X_SPEED);
    localparam logic signed [15:0]   VY_ACC    = 16'(Y_ACCEL);
    localparam logic [2:0]           SZ_MAX    = 3'(MAX_SIZE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_MOVE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic signed [PW-1:0]  x_q, x_d, y_q, y_d;
    logic signed [15:0]    vx_q, vx_d, vy_q, vy_d;
    logic [2:0]            sz_q, sz_d;
    logic [2:0]            child_size_q, child_size_d;
    logic [10:0]           child_x_q, child_x_d, child_y_q, child_y_d;

    logic signed [EW-1:0]  w, nx, ny;
    logic signed [15:0]    bounce;
    logic                  hit_ok, nx_le0, ny_le0, vx_neg, vx_pos, vy_neg, vy_pos;

    assign topLeftX = x_q[FRAC_BITS +: 11];
    assign topLeftY = y_q[FRAC_BITS +: 11];

    // Next-state and motion arithmetic; collisions pre-empt gravity on a frame.
    always_comb begin
        w      = EW'((OBJECT_SIZE << sz_q) * M);
        nx     = EW'(x_q) + EW'(vx_q);
        ny     = EW'(y_q) + EW'(vy_q);
        bounce = 16'(BOUNCE_BASE + 32'(sz_q) * BOUNCE_STEP);
        hit_ok = (state_q == S_MOVE) && Hit;
        nx_le0 = nx[EW-1] || (nx == '0);
        ny_le0 = ny[EW-1] || (ny == '0);
        vx_neg = vx_q[15];
        vx_pos = !vx_q[15] && (vx_q != '0);
        vy_neg = vy_q[15];
        vy_pos = !vy_q[15] && (vy_q != '0);

        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        vx_d         = vx_q;
        vy_d         = vy_q;
        sz_d         = sz_q;
        child_size_d = child_size_q;
        child_x_d    = child_x_q;
        child_y_d    = child_y_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    x_d     = PW'({startTopX, {FRAC_BITS{1'b0}}});
                    y_d     = PW'({startTopY, {FRAC_BITS{1'b0}}});
                    vx_d    = direction ? VX_INIT : -VX_INIT;
                    vy_d    = '0;
                    sz_d    = (size > SZ_MAX) ? SZ_MAX : size;
                end
            end
            S_LOAD: state_d = S_MOVE;
            S_MOVE: begin
                if (Hit) begin
                    state_d      = S_IDLE;
                    x_d          = IDLE_POS;
                    y_d          = IDLE_POS;
                    vx_d         = VX_INIT;
                    vy_d         = '0;
                    sz_d         = '0;
                    child_size_d = sz_q - 3'd1;
                    child_x_d    = topLeftX;
                    child_y_d    = topLeftY;
                end else if (startOfFrame && !pause) begin
                    if (nx_le0 && vx_neg) begin
                        x_d  = '0;
                        vx_d = -vx_q;
                    end else if (((nx + w) >= FRAME_W_S) && vx_pos) begin
                        x_d  = PW'(FRAME_W_S - w);
                        vx_d = -vx_q;
                    end else begin
                        x_d  = PW'(nx);
                    end

                    if (((ny + w) >= FRAME_H_S) && vy_pos) begin
                        y_d  = PW'(FRAME_H_S - w);
                        vy_d = -bounce;
                    end else if (ny_le0 && vy_neg) begin
                        y_d  = '0;
                        vy_d = -vy_q;
                    end else begin
                        y_d  = PW'(ny);
                        vy_d = vy_q + VY_ACC;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            x_q          <= IDLE_POS;
            y_q          <= IDLE_POS;
            vx_q         <= VX_INIT;
            vy_q         <= '0;
            sz_q         <= '0;
            child_size_q <= '0;
            child_x_q    <= '0;
            child_y_q    <= '0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            vx_q         <= vx_d;
            vy_q         <= vy_d;
            sz_q         <= sz_d;
            child_size_q <= child_size_d;
            child_x_q    <= child_x_d;
            child_y_q    <= child_y_d;
        end
    end

    assign size_out   = sz_q;
    assign active     = (state_q == S_MOVE);
    assign split      = hit_ok && (sz_q != 3'd0);
    assign pop        = hit_ok && (sz_q == 3'd0);
    assign child_size = child_size_q;
    assign child_x    = child_x_q;
    assign child_y    = child_y_q;

endmodule

// File: tb/tb_bubble_move_gen.sv
// Scoreboard bench for bubble_move_gen: an integer reference model predicts every
// frame's position and every split/pop; a negedge monitor pops and compares.
module tb_bubble_move_gen;

    localparam int M = 64, FW = 640, FH = 480, OS = 8, MAXS = 4;
    localparam int XS = 115, YA = 2, BB = 320, BS = 64;

    logic        clk, reset, startOfFrame, start, direction, pause, Hit;
    logic [2:0]  size;
    logic [10:0] startTopX, startTopY;
    logic [10:0] topLeftX, topLeftY, child_x, child_y;
    logic [2:0]  size_out, child_size;
    logic        active, split, pop;

    bubble_move_gen dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .start(start),
        .size(size), .direction(direction), .startTopX(startTopX), .startTopY(startTopY),
        .pause(pause), .Hit(Hit), .topLeftX(topLeftX), .topLeftY(topLeftY),
        .size_out(size_out), .active(active), .split(split), .pop(pop),
        .child_size(child_size), .child_x(child_x), .child_y(child_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [10:0] x; logic [10:0] y; logic [2:0] s; logic a; } pos_t;
    typedef struct { logic sp; logic po; logic [2:0] cs; logic [10:0] cx; logic [10:0] cy; } ev_t;
    pos_t pos_q[$];
    ev_t  ev_q[$];

    int checks = 0, failures = 0;
    int m_x, m_y, m_vx, m_vy, m_sz;
    bit m_act;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Floor division by the sub-pixel multiplier, then the 11-bit screen view.
    function automatic int fl(input int v);
        return (v >= 0) ? v / M : -((-v + M - 1) / M);
    endfunction
    function automatic logic [10:0] px(input int v);
        return 11'(fl(v));
    endfunction

    task automatic m_idle();
        m_x = -M; m_y = -M; m_vx = XS; m_vy = 0; m_sz = 0; m_act = 0;
    endtask

    task automatic m_frame();
        int w, nx, ny;
        w  = (OS << m_sz) * M;
        nx = m_x + m_vx;
        ny = m_y + m_vy;
        if (nx <= 0 && m_vx < 0) begin m_x = 0; m_vx = -m_vx; end
        else if (nx + w >= FW * M && m_vx > 0) begin m_x = FW * M - w; m_vx = -m_vx; end
        else m_x = nx;
        if (ny + w >= FH * M && m_vy > 0) begin m_y = FH * M - w; m_vy = -(BB + m_sz * BS); end
        else if (ny <= 0 && m_vy < 0) begin m_y = 0; m_vy = -m_vy; end
        else begin m_y = ny; m_vy = m_vy + YA; end
    endtask

    task automatic push_hit();
        ev_t e;
        e.sp = (m_sz != 0); e.po = (m_sz == 0); e.cs = 3'(m_sz - 1);
        e.cx = px(m_x); e.cy = px(m_y);
        ev_q.push_back(e);
        m_idle();
    endtask

    task automatic launch(input int s, input bit d, input int x, input int y);
        start = 1'b1; size = 3'(s); direction = d; startTopX = 11'(x); startTopY = 11'(y);
        @(posedge clk); #1;
        start = 1'b0;
        chk("latency_active_low", 32'(active), 32'd0);
        m_x = x * M; m_y = y * M; m_vx = d ? XS : -XS; m_vy = 0;
        m_sz = (s > MAXS) ? MAXS : s;
        @(posedge clk); #1;
        m_act = 1;
        chk("launch_active", 32'(active), 32'd1);
        chk("launch_x", 32'(topLeftX), 32'(px(m_x)));
        chk("launch_y", 32'(topLeftY), 32'(px(m_y)));
        chk("launch_size", 32'(size_out), 32'(m_sz));
    endtask

    task automatic frame(input bit p, input bit h);
        pos_t e;
        startOfFrame = 1'b1; pause = p; Hit = h;
        if (h && m_act) push_hit();
        else if (!p && m_act) m_frame();
        e.x = px(m_x); e.y = px(m_y); e.s = 3'(m_sz); e.a = m_act;
        pos_q.push_back(e);
        @(posedge clk); #1;
        startOfFrame = 1'b0; Hit = 1'b0;
    endtask

    task automatic hit_only();
        Hit = 1'b1;
        push_hit();
        @(posedge clk); #1;
        Hit = 1'b0;
        chk("post_hit_active", 32'(active), 32'd0);
        chk("post_hit_x", 32'(topLeftX), 32'h7FF);
        chk("post_hit_y", 32'(topLeftY), 32'h7FF);
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #0;
    endtask

    // Monitor: compares a position sample after every frame pulse and every event pulse.
    bit   sof_seen = 1'b0, child_pend = 1'b0;
    pos_t p_cur;
    ev_t  e_cur;
    always @(posedge clk) sof_seen <= startOfFrame && !reset;

    always @(negedge clk) begin
        if (child_pend) begin
            chk("child_size", 32'(child_size), 32'(e_cur.cs));
            chk("child_x", 32'(child_x), 32'(e_cur.cx));
            chk("child_y", 32'(child_y), 32'(e_cur.cy));
            child_pend = 1'b0;
        end
        if (sof_seen) begin
            if (pos_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL frame_unexpected actual=sample required=none at %0t", $time);
            end else begin
                p_cur = pos_q.pop_front();
                chk("frame_x", 32'(topLeftX), 32'(p_cur.x));
                chk("frame_y", 32'(topLeftY), 32'(p_cur.y));
                chk("frame_size", 32'(size_out), 32'(p_cur.s));
                chk("frame_active", 32'(active), 32'(p_cur.a));
            end
        end
        if (split === 1'b1 || pop === 1'b1) begin
            if (ev_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL event_unexpected actual=split%0b_pop%0b required=none at %0t",
                         split, pop, $time);
            end else begin
                e_cur = ev_q.pop_front();
                chk("event_split", 32'(split), 32'(e_cur.sp));
                chk("event_pop", 32'(pop), 32'(e_cur.po));
                child_pend = e_cur.sp;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; startOfFrame = 0; start = 0; size = 0; direction = 0;
        startTopX = 0; startTopY = 0; pause = 0; Hit = 0;
        m_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_x", 32'(topLeftX), 32'h7FF);
        chk("rst_y", 32'(topLeftY), 32'h7FF);
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_split_pop", 32'({split, pop}), 32'd0);
        chk("rst_size", 32'(size_out), 32'd0);
        chk("rst_child", 32'({child_size, child_x, child_y}), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Launch and first two frames of motion.
        launch(1, 1, 100, 50);
        frame(0, 0); chk("launch_f1_x", 32'(topLeftX), 32'd101);
        frame(0, 0); chk("launch_f2_y", 32'(topLeftY), 32'd50);
        hit_only();
        @(posedge clk); #1;

        // Right wall rebound.
        launch(0, 1, 631, 100);
        frame(0, 0); chk("wall_x", 32'(topLeftX), 32'd632);
        frame(0, 0); chk("wall_back_x", 32'(topLeftX), 32'd630);
        hit_only();
        @(posedge clk); #1;

        // Floor bounce at size 2.
        launch(2, 1, 200, 440);
        for (int i = 0; i < 200 && m_vy != -448; i++) frame(0, 0);
        chk("floor_y", 32'(topLeftY), 32'd448);
        frame(0, 0); chk("floor_up_y", 32'(topLeftY), 32'd441);
        hit_only();
        @(posedge clk); #1;

        // Split at size 2 and pop at size 0.
        launch(2, 0, 200, 100);
        hit_only();
        @(negedge clk);
        chk("split_child", 32'({child_size, child_x, child_y}), 32'({3'd1, 11'd200, 11'd100}));
        @(posedge clk); #1;
        launch(0, 0, 300, 200);
        hit_only();

        // Oversized launch is clamped.
        launch(7, 1, 50, 50);
        frame(0, 0);
        hit_only();

        // Pause freezes motion; hit during pause still splits.
        launch(3, 0, 300, 100);
        repeat (3) frame(0, 0);
        repeat (5) begin frame(1, 0); gap(); end
        frame(0, 0);
        frame(1, 1);
        @(posedge clk); #1;

        // Hit coinciding with a frame pulse, and start ignored in MOVE.
        launch(1, 1, 100, 100);
        frame(0, 0);
        start = 1'b1; startTopX = 11'd500; startTopY = 11'd10;
        @(posedge clk); #1;
        start = 1'b0;
        frame(0, 0);
        chk("start_ignored_active", 32'(active), 32'd1);
        frame(0, 1);

        // Asynchronous reset mid-MOVE.
        launch(2, 1, 300, 200);
        frame(0, 0);
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        m_idle();
        chk("amid_rst_x", 32'(topLeftX), 32'h7FF);
        chk("amid_rst_y", 32'(topLeftY), 32'h7FF);
        chk("amid_rst_active", 32'(active), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Randomized flights.
        for (int n = 0; n < 15; n++) begin
            int s, cs, w;
            s  = $urandom_range(0, 7);
            cs = (s > MAXS) ? MAXS : s;
            w  = OS << cs;
            launch(s, 1'($urandom_range(0, 1)), $urandom_range(0, FW - w), $urandom_range(0, FH - w));
            repeat ($urandom_range(20, 150)) begin
                frame(($urandom_range(0, 7) == 0), 1'b0);
                gap();
            end
            if ($urandom_range(0, 1) == 1) frame(1'($urandom_range(0, 1)), 1'b1);
            else hit_only();
            repeat (2) @(posedge clk);
            #1;
        end

        repeat (3) @(posedge clk);
        #1;
        chk("drain_pos_q", 32'(pos_q.size()), 32'd0);
        chk("drain_ev_q", 32'(ev_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
